// File: rtl/hv_encoder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hv_encoder_ctrl_pkg
// Purpose  : Control-word layout, FSM states and strobe mask shared by the
//            hypervector encoder micro-sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package hv_encoder_ctrl_pkg;

  typedef struct packed {
    logic [1:0] alu_mux_a;
    logic [1:0] alu_mux_b;
    logic [2:0] alu_ops;
    logic [6:0] alu_shift_amt;
    logic [1:0] bund_mux_a;
    logic [1:0] bund_mux_b;
    logic       bund_valid_a;
    logic       bund_valid_b;
    logic       bund_clr_a;
    logic       bund_clr_b;
    logic [1:0] reg_mux;
    logic [1:0] reg_rd_addr_a;
    logic [1:0] reg_rd_addr_b;
    logic [1:0] reg_wr_addr;
    logic       reg_wr_en;
    logic       qhv_wen;
    logic       qhv_clr;
    logic [1:0] qhv_mux;
    logic       qhv_am_load;
  } hv_ctrl_inst_t;

  localparam int c_inst_width = $bits(hv_ctrl_inst_t);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ctrl_state_e;

  // Fields with side effects in the encoder; these must be silent on stalls.
  localparam hv_ctrl_inst_t c_strobe_mask = '{
    alu_mux_a: 2'b0, alu_mux_b: 2'b0, alu_ops: 3'b0, alu_shift_amt: 7'b0,
    bund_mux_a: 2'b0, bund_mux_b: 2'b0,
    bund_valid_a: 1'b1, bund_valid_b: 1'b1, bund_clr_a: 1'b1, bund_clr_b: 1'b1,
    reg_mux: 2'b0, reg_rd_addr_a: 2'b0, reg_rd_addr_b: 2'b0, reg_wr_addr: 2'b0,
    reg_wr_en: 1'b1,
    qhv_wen: 1'b1, qhv_clr: 1'b1, qhv_mux: 2'b0, qhv_am_load: 1'b1
  };

  function automatic hv_ctrl_inst_t gate_strobes(input hv_ctrl_inst_t w, input logic issue);
    return issue ? w : hv_ctrl_inst_t'(w & ~c_strobe_mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hv_ctrl_loop_unit.sv
`default_nettype none
// ============================================================================
// Module   : hv_ctrl_loop_unit
// Purpose  : Next-pc / next-iteration logic for the single hardware loop.
// Revision : 1.0 - initial release
// ============================================================================
module hv_ctrl_loop_unit #(
  parameter int IMEM_DEPTH  = 16,
  parameter int COUNT_WIDTH = 8,
  parameter int PC_WIDTH    = $clog2(IMEM_DEPTH)
) (
  input  logic [PC_WIDTH-1:0]    i_pc,
  input  logic [COUNT_WIDTH-1:0] i_iter,
  input  logic [PC_WIDTH-1:0]    i_loop_start,
  input  logic [PC_WIDTH-1:0]    i_loop_end,
  input  logic [COUNT_WIDTH-1:0] i_loop_count,
  input  logic [PC_WIDTH-1:0]    i_prog_end,
  output logic [PC_WIDTH-1:0]    o_pc_next,
  output logic [COUNT_WIDTH-1:0] o_iter_next,
  output logic                   o_prog_last
);

  logic [COUNT_WIDTH-1:0] w_iter_max;
  logic [PC_WIDTH-1:0]    w_pc_inc;
  logic                   w_at_loop_end;
  logic                   w_take_loop;

  // A zero count still runs the body once.
  assign w_iter_max    = (i_loop_count == '0) ? '0 : i_loop_count - COUNT_WIDTH'(1);
  assign w_at_loop_end = (i_pc == i_loop_end);
  assign w_take_loop   = w_at_loop_end && (i_iter < w_iter_max);
  assign w_pc_inc      = (i_pc == PC_WIDTH'(IMEM_DEPTH - 1)) ? '0 : i_pc + PC_WIDTH'(1);

  always_comb begin
    o_pc_next   = w_pc_inc;
    o_iter_next = i_iter;
    o_prog_last = 1'b0;
    if (w_take_loop) begin
      o_pc_next   = i_loop_start;
      o_iter_next = i_iter + COUNT_WIDTH'(1);
    end else begin
      if (w_at_loop_end) begin
        o_iter_next = '0;
      end
      if (i_pc == i_prog_end) begin
        o_prog_last = 1'b1;
        o_pc_next   = '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hv_encoder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hv_encoder_ctrl
// Purpose  : Programmable micro-sequencer issuing encoder control words with
//            one hardware loop. Optional perf counters: HV_ENCODER_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hv_encoder_ctrl
  import hv_encoder_ctrl_pkg::*;
#(
  parameter int IMEM_DEPTH  = 16,
  parameter int COUNT_WIDTH = 8,
  parameter int INST_WIDTH  = c_inst_width,
  parameter int PC_WIDTH    = $clog2(IMEM_DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   imem_wr_en_i,
  input  logic [PC_WIDTH-1:0]    imem_wr_addr_i,
  input  logic [INST_WIDTH-1:0]  imem_wr_data_i,
  input  logic [PC_WIDTH-1:0]    loop_start_i,
  input  logic [PC_WIDTH-1:0]    loop_end_i,
  input  logic [COUNT_WIDTH-1:0] loop_count_i,
  input  logic [PC_WIDTH-1:0]    prog_end_i,
  input  logic                   start_i,
  input  logic                   global_stall_i,
  input  logic                   qhv_stall_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [PC_WIDTH-1:0]    pc_o,
  output logic [INST_WIDTH-1:0]  encoder_ctrl_o
`ifdef HV_ENCODER_CTRL_PERF_EN
  ,
  output logic [31:0]            perf_issue_o,
  output logic [31:0]            perf_gstall_o,
  output logic [31:0]            perf_qstall_o
`endif
);

  ctrl_state_e r_state, w_state_next;

  logic [PC_WIDTH-1:0]    r_pc, w_pc_next;
  logic [COUNT_WIDTH-1:0] r_iter, w_iter_next;
  logic                   w_prog_last;

  logic [PC_WIDTH-1:0]    r_loop_start, r_loop_end, r_prog_end;
  logic [COUNT_WIDTH-1:0] r_loop_count;

  logic [INST_WIDTH-1:0]  r_imem [IMEM_DEPTH];
  logic [INST_WIDTH-1:0]  w_word;

  logic w_run, w_stall, w_issue, w_start_acc;

  assign w_run       = (r_state == ST_RUN);
  assign w_stall     = global_stall_i | qhv_stall_i;
  assign w_issue     = w_run & ~w_stall;
  assign w_start_acc = (r_state == ST_IDLE) & start_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start_i) w_state_next = ST_RUN;
      ST_RUN:  if (w_issue && w_prog_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Loop/program bounds are shadowed so host writes mid-run are harmless.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pc         <= '0;
      r_iter       <= '0;
      r_loop_start <= '0;
      r_loop_end   <= '0;
      r_loop_count <= '0;
      r_prog_end   <= '0;
    end else if (w_start_acc) begin
      r_pc         <= '0;
      r_iter       <= '0;
      r_loop_start <= loop_start_i;
      r_loop_end   <= loop_end_i;
      r_loop_count <= loop_count_i;
      r_prog_end   <= prog_end_i;
    end else if (w_issue) begin
      r_pc         <= w_pc_next;
      r_iter       <= w_iter_next;
    end
  end

  hv_ctrl_loop_unit #(
    .IMEM_DEPTH  (IMEM_DEPTH),
    .COUNT_WIDTH (COUNT_WIDTH),
    .PC_WIDTH    (PC_WIDTH)
  ) u_loop_unit (
    .i_pc         (r_pc),
    .i_iter       (r_iter),
    .i_loop_start (r_loop_start),
    .i_loop_end   (r_loop_end),
    .i_loop_count (r_loop_count),
    .i_prog_end   (r_prog_end),
    .o_pc_next    (w_pc_next),
    .o_iter_next  (w_iter_next),
    .o_prog_last  (w_prog_last)
  );

  always_ff @(posedge clk_i) begin
    if (imem_wr_en_i && (r_state == ST_IDLE)) begin
      r_imem[imem_wr_addr_i] <= imem_wr_data_i;
    end
  end

  assign w_word = r_imem[r_pc];

  always_comb begin
    encoder_ctrl_o = '0;
    if (w_run) begin
      encoder_ctrl_o = gate_strobes(hv_ctrl_inst_t'(w_word), w_issue);
    end
  end

  assign busy_o = (r_state != ST_IDLE);
  assign done_o = (r_state == ST_DONE);
  assign pc_o   = r_pc;

`ifdef HV_ENCODER_CTRL_PERF_EN
  logic [31:0] r_perf_issue, r_perf_gstall, r_perf_qstall;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || w_start_acc) begin
      r_perf_issue  <= '0;
      r_perf_gstall <= '0;
      r_perf_qstall <= '0;
    end else begin
      if (w_issue && (r_perf_issue != '1)) begin
        r_perf_issue <= r_perf_issue + 32'd1;
      end
      if (w_run && global_stall_i && (r_perf_gstall != '1)) begin
        r_perf_gstall <= r_perf_gstall + 32'd1;
      end
      if (w_run && qhv_stall_i && !global_stall_i && (r_perf_qstall != '1)) begin
        r_perf_qstall <= r_perf_qstall + 32'd1;
      end
    end
  end

  assign perf_issue_o  = r_perf_issue;
  assign perf_gstall_o = r_perf_gstall;
  assign perf_qstall_o = r_perf_qstall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hv_encoder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hv_encoder_ctrl
// Purpose  : Scoreboard bench for the encoder micro-sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hv_encoder_ctrl;

  localparam logic [35:0] MASK = 36'h0_0003_C039;

  typedef struct packed {
    logic [3:0]  pc;
    logic [35:0] ctrl;
    logic        done;
  } exp_t;

  exp_t q[$];
  exp_t mon_exp, mon_act;
  int   total = 0;
  int   bad   = 0;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_wr_en_i = 1'b0;
  logic [3:0]  imem_wr_addr_i = '0;
  logic [35:0] imem_wr_data_i = '0;
  logic [3:0]  loop_start_i = '0;
  logic [3:0]  loop_end_i = '0;
  logic [7:0]  loop_count_i = '0;
  logic [3:0]  prog_end_i = '0;
  logic        start_i = 1'b0;
  logic        global_stall_i = 1'b0;
  logic        qhv_stall_i = 1'b0;
  logic        busy_o, done_o;
  logic [3:0]  pc_o;
  logic [35:0] encoder_ctrl_o;
`ifdef HV_ENCODER_CTRL_PERF_EN
  logic [31:0] perf_issue_o, perf_gstall_o, perf_qstall_o;
`endif

  logic [35:0] tb_mem [4];

  always #5 clk = ~clk;

  hv_encoder_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .imem_wr_en_i   (imem_wr_en_i),
    .imem_wr_addr_i (imem_wr_addr_i),
    .imem_wr_data_i (imem_wr_data_i),
    .loop_start_i   (loop_start_i),
    .loop_end_i     (loop_end_i),
    .loop_count_i   (loop_count_i),
    .prog_end_i     (prog_end_i),
    .start_i        (start_i),
    .global_stall_i (global_stall_i),
    .qhv_stall_i    (qhv_stall_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .pc_o           (pc_o),
    .encoder_ctrl_o (encoder_ctrl_o)
`ifdef HV_ENCODER_CTRL_PERF_EN
    ,
    .perf_issue_o   (perf_issue_o),
    .perf_gstall_o  (perf_gstall_o),
    .perf_qstall_o  (perf_qstall_o)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle(input logic g, input logic qs);
    @(posedge clk);
    #1;
    start_i        = 1'b0;
    imem_wr_en_i   = 1'b0;
    global_stall_i = g;
    qhv_stall_i    = qs;
  endtask

  task automatic issue(input int p);
    next_cycle(1'b0, 1'b0);
    q.push_back('{pc: 4'(p), ctrl: tb_mem[p], done: 1'b0});
  endtask

  task automatic stall(input int p, input logic g, input logic qs);
    next_cycle(g, qs);
    q.push_back('{pc: 4'(p), ctrl: tb_mem[p] & ~MASK, done: 1'b0});
  endtask

  task automatic done_cyc();
    next_cycle(1'b0, 1'b0);
    q.push_back('{pc: 4'd0, ctrl: 36'd0, done: 1'b1});
  endtask

  task automatic kick(input int ls, input int le, input int cnt, input int pe);
    next_cycle(1'b0, 1'b0);
    loop_start_i = 4'(ls);
    loop_end_i   = 4'(le);
    loop_count_i = 8'(cnt);
    prog_end_i   = 4'(pe);
    start_i      = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    next_cycle(1'b0, 1'b0);
    @(negedge clk);
    chk({tag, "_busy_low"}, 64'(busy_o), 64'd0);
    chk({tag, "_queue_drained"}, 64'(q.size()), 64'd0);
  endtask

  // Monitor: every busy cycle must match the next expected record.
  always @(negedge clk) begin
    if (rst_ni && busy_o !== 1'b0) begin
      mon_act = '{pc: pc_o, ctrl: encoder_ctrl_o, done: done_o};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_busy: pc=%0d ctrl=%h done=%b, no cycle expected",
                 pc_o, encoder_ctrl_o, done_o);
      end else begin
        mon_exp = q.pop_front();
        if (mon_act !== mon_exp) begin
          bad++;
          $display("FAIL cycle: got pc=%0d ctrl=%h done=%b, expected pc=%0d ctrl=%h done=%b",
                   mon_act.pc, mon_act.ctrl, mon_act.done,
                   mon_exp.pc, mon_exp.ctrl, mon_exp.done);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tb_mem[0] = 36'h1_2340_0100;
    tb_mem[1] = 36'hF_FFFF_FFEF;
    tb_mem[2] = 36'h8_0003_C029;
    tb_mem[3] = 36'h0_0000_0010;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_done", 64'(done_o), 64'd0);
    chk("reset_pc",   64'(pc_o), 64'd0);
    chk("reset_ctrl", 64'(encoder_ctrl_o), 64'd0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    for (int i = 0; i < 4; i++) begin
      next_cycle(1'b0, 1'b0);
      imem_wr_en_i   = 1'b1;
      imem_wr_addr_i = 4'(i);
      imem_wr_data_i = tb_mem[i];
    end

    // Straight-line program, count 0 behaves as a single pass.
    kick(0, 3, 0, 3);
    issue(0); issue(1); issue(2); issue(3);
    done_cyc();
    check_idle("straight");

    // Loop body 1..2 three times, with two global stalls on the first pc 1.
    kick(1, 2, 3, 3);
    issue(0);
    stall(1, 1'b1, 1'b0);
    stall(1, 1'b1, 1'b0);
    issue(1); issue(2); issue(1); issue(2); issue(1); issue(2); issue(3);
    done_cyc();
    check_idle("loop");
`ifdef HV_ENCODER_CTRL_PERF_EN
    chk("perf_issue_loop",  64'(perf_issue_o), 64'd8);
    chk("perf_gstall_loop", 64'(perf_gstall_o), 64'd2);
    chk("perf_qstall_loop", 64'(perf_qstall_o), 64'd0);
`endif

    // Mixed stalls: two global then one qhv-only, all at pc 1.
    kick(0, 3, 0, 3);
    issue(0);
    stall(1, 1'b1, 1'b0);
    stall(1, 1'b1, 1'b1);
    stall(1, 1'b0, 1'b1);
    issue(1); issue(2); issue(3);
    done_cyc();
    check_idle("stall");
`ifdef HV_ENCODER_CTRL_PERF_EN
    chk("perf_issue_stall",  64'(perf_issue_o), 64'd4);
    chk("perf_gstall_stall", 64'(perf_gstall_o), 64'd2);
    chk("perf_qstall_stall", 64'(perf_qstall_o), 64'd1);
`endif

    // Write, restart and config change while busy must all be ignored.
    kick(0, 3, 0, 3);
    issue(0);
    issue(1);
    imem_wr_en_i   = 1'b1;
    imem_wr_addr_i = 4'd2;
    imem_wr_data_i = 36'hD_EADB_EEF0;
    start_i        = 1'b1;
    prog_end_i     = 4'd1;
    issue(2);
    issue(3);
    done_cyc();
    start_i = 1'b1;
    check_idle("protect");

    // Loop end beyond program end, program of one word.
    kick(0, 3, 5, 0);
    issue(0);
    done_cyc();
    check_idle("single");

    // Reset while pc=2 aborts without done.
    kick(0, 3, 0, 3);
    issue(0); issue(1); issue(2);
    @(negedge clk);
    #1;
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_done", 64'(done_o), 64'd0);
    chk("abort_pc",   64'(pc_o), 64'd0);
    chk("abort_ctrl", 64'(encoder_ctrl_o), 64'd0);
    chk("abort_queue_drained", 64'(q.size()), 64'd0);

    // Memory must survive the reset.
    kick(0, 3, 0, 3);
    issue(0); issue(1); issue(2); issue(3);
    done_cyc();
    check_idle("retain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
